piso_32_bit_serializer: RTL and testbench

Parallel-in, serial-out serializer that accepts 32-bit words over a valid/ready handshake and emits them one bit per clock as a continuous serial stream. It sits directly upstream of the 32-bit SISO shift register and drives its serial data input. A one-word holding register allows gapless back-to-back frames.

---
 rtl/piso_32_bit_serializer_if.sv | 29 ++
 rtl/piso_32_bit_serializer.sv | 133 +++++++++++++
 tb/tb_piso_32_bit_serializer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_32_bit_serializer_if.sv
// Handshake and serial-stream bundle for piso_32_bit_serializer.
// The master drives the parallel word. The slave is the serializer itself.
interface piso_32_bit_serializer_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

   logic [DATA_WIDTH-1:0] Parallel_Data_In;
   logic                  Data_Valid_In;
   logic                  Data_Ready_Out;
   logic                  Serial_Data_Out;
   logic                  Serial_Valid_Out;
   logic                  Frame_Start_Out;
   logic                  Parity_Flag_Out;
   logic [CNT_W-1:0]      Bit_Count_Out;
   logic                  Busy_Out;

   modport master (
      output Parallel_Data_In, Data_Valid_In,
      input  Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Frame_Start_Out,
      input  Parity_Flag_Out, Bit_Count_Out, Busy_Out
   );

   modport slave (
      input  Parallel_Data_In, Data_Valid_In,
      output Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Frame_Start_Out,
      output Parity_Flag_Out, Bit_Count_Out, Busy_Out
   );
endinterface

// File: rtl/piso_32_bit_serializer.sv
// Parallel-in serial-out serializer with a one-word holding register for gapless frames.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_32_bit_serializer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input logic Clk_In,
   input logic Reset_In,
   piso_32_bit_serializer_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
`ifdef PISO_PARITY_EN
   localparam int unsigned FrameLen = DATA_WIDTH + 1;
`else
   localparam int unsigned FrameLen = DATA_WIDTH;
`endif

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  accept, last_bit, load_in, load_hold, hold_wr;
   logic                  data_bit;
   logic [DATA_WIDTH-1:0] shifted;

   assign accept   = bus.Data_Valid_In & ~hold_full_q;
   assign last_bit = (cnt_q == CNT_W'(FrameLen - 1));
   assign data_bit = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
   assign shifted  = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[DATA_WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;
      load_in     = 1'b0;
      load_hold   = 1'b0;
      hold_wr     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) load_in = 1'b1;
         end
         StShift: begin
            if (last_bit) begin
               // Held word has priority; Ready is low while it is present.
               if (hold_full_q) begin
                  load_hold = 1'b1;
               end else if (accept) begin
                  load_in = 1'b1;
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end else begin
               shift_d = shifted;
               cnt_d   = cnt_q + 1'b1;
               if (accept) hold_wr = 1'b1;
            end
         end
      endcase
      if (load_in) begin
         shift_d = bus.Parallel_Data_In;
         cnt_d   = '0;
         state_d = StShift;
      end
      if (load_hold) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         cnt_d       = '0;
      end
      if (hold_wr) begin
         hold_d      = bus.Parallel_Data_In;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge Clk_In or negedge Reset_In) begin
      if (!Reset_In) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef PISO_PARITY_EN
   logic par_q, par_d, hold_par_q, hold_par_d, par_cycle;

   always_comb begin
      par_d      = par_q;
      hold_par_d = hold_par_q;
      if (load_in) par_d = ^bus.Parallel_Data_In;
      else if (load_hold) par_d = hold_par_q;
      if (hold_wr) hold_par_d = ^bus.Parallel_Data_In;
   end

   always_ff @(posedge Clk_In or negedge Reset_In) begin
      if (!Reset_In) begin
         par_q      <= 1'b0;
         hold_par_q <= 1'b0;
      end else begin
         par_q      <= par_d;
         hold_par_q <= hold_par_d;
      end
   end

   assign par_cycle           = (state_q == StShift) && (cnt_q == CNT_W'(DATA_WIDTH));
   assign bus.Parity_Flag_Out = par_cycle;
   assign bus.Serial_Data_Out = (state_q == StShift) & (par_cycle ? par_q : data_bit);
`else
   assign bus.Parity_Flag_Out = 1'b0;
   assign bus.Serial_Data_Out = (state_q == StShift) & data_bit;
`endif

   assign bus.Data_Ready_Out   = ~hold_full_q;
   assign bus.Serial_Valid_Out = (state_q == StShift);
   assign bus.Busy_Out         = (state_q == StShift);
   assign bus.Frame_Start_Out  = (state_q == StShift) && (cnt_q == '0);
   assign bus.Bit_Count_Out    = cnt_q;
endmodule

// File: tb/tb_piso_32_bit_serializer.sv
// Directed bench for piso_32_bit_serializer: one MSB-first and one LSB-first instance.
// Frames are reassembled by a downstream shift model and compared to the sent words.
module tb_piso_32_bit_serializer;
`ifdef PISO_PARITY_EN
   localparam int FL = 33;
`else
   localparam int FL = 32;
`endif

   typedef struct {
      logic [31:0] word;
      bit          msb;
      bit          first;
      bit          last;
      bit          par;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[6];

   piso_32_bit_serializer_if #(.DATA_WIDTH(32)) bm ();
   piso_32_bit_serializer_if #(.DATA_WIDTH(32)) bl ();

   piso_32_bit_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
      .Clk_In(clk), .Reset_In(rst_n), .bus(bm)
   );
   piso_32_bit_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
      .Clk_In(clk), .Reset_In(rst_n), .bus(bl)
   );

   always #5 clk = ~clk;

   logic       s_ser, s_vld, s_fs, s_pf, s_busy, s_rdy;
   logic [5:0] s_cnt;
   assign s_ser  = sel ? bm.Serial_Data_Out  : bl.Serial_Data_Out;
   assign s_vld  = sel ? bm.Serial_Valid_Out : bl.Serial_Valid_Out;
   assign s_fs   = sel ? bm.Frame_Start_Out  : bl.Frame_Start_Out;
   assign s_pf   = sel ? bm.Parity_Flag_Out  : bl.Parity_Flag_Out;
   assign s_busy = sel ? bm.Busy_Out         : bl.Busy_Out;
   assign s_rdy  = sel ? bm.Data_Ready_Out   : bl.Data_Ready_Out;
   assign s_cnt  = sel ? bm.Bit_Count_Out    : bl.Bit_Count_Out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit s, input logic v, input logic [31:0] d);
      if (s) begin
         bm.Data_Valid_In = v; bm.Parallel_Data_In = d;
      end else begin
         bl.Data_Valid_In = v; bl.Parallel_Data_In = d;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts output cycles that are not the quiet idle pattern.
   task automatic idle_bad(output int bad);
      bad = 0;
      if (s_ser !== 1'b0 || s_vld !== 1'b0 || s_fs !== 1'b0 || s_pf !== 1'b0) bad++;
      if (s_busy !== 1'b0 || s_cnt !== 6'd0 || s_rdy !== 1'b1) bad++;
   endtask

   // Starts with bit 0 on the line; ends just after the edge following the frame's last bit.
   task automatic capture_frame(input bit msb, output logic [31:0] rec);
      rec = '0;
      for (int i = 0; i < FL; i++) begin
         if (i < 32) begin
            if (msb) rec = {rec[30:0], s_ser};
            else     rec = {s_ser, rec[31:1]};
         end
         tick();
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] rec;
      int          fs_bad, cnt_bad, vld_bad, pf_bad;
      logic        first_b, last_b;
      rec = '0; fs_bad = 0; cnt_bad = 0; vld_bad = 0; pf_bad = 0;
      first_b = 1'bx; last_b = 1'bx;
      sel = v.msb;
      #1;
      chk($sformatf("v%0d_ready_idle", idx), {31'd0, s_rdy}, 32'd1);
      drive(v.msb, 1'b1, v.word);
      tick();
      drive(v.msb, 1'b0, 32'd0);
      for (int i = 0; i < FL; i++) begin
         if (s_fs !== (i == 0)) fs_bad++;
         if (s_cnt !== 6'(i)) cnt_bad++;
         if (s_vld !== 1'b1 || s_busy !== 1'b1) vld_bad++;
         if (i < 32) begin
            if (v.msb) rec = {rec[30:0], s_ser};
            else       rec = {s_ser, rec[31:1]};
            if (i == 0)  first_b = s_ser;
            if (i == 31) last_b  = s_ser;
            if (s_pf !== 1'b0) pf_bad++;
         end
`ifdef PISO_PARITY_EN
         if (i == 32) begin
            if (s_pf !== 1'b1) pf_bad++;
            chk($sformatf("v%0d_parity_bit", idx), {31'd0, s_ser}, {31'd0, v.par});
         end
`endif
         tick();
      end
      chk($sformatf("v%0d_word", idx), rec, v.word);
      chk($sformatf("v%0d_first_bit", idx), {31'd0, first_b}, {31'd0, v.first});
      chk($sformatf("v%0d_last_bit", idx), {31'd0, last_b}, {31'd0, v.last});
      chk($sformatf("v%0d_frame_start_bad", idx), fs_bad, 0);
      chk($sformatf("v%0d_bit_count_bad", idx), cnt_bad, 0);
      chk($sformatf("v%0d_valid_busy_bad", idx), vld_bad, 0);
      chk($sformatf("v%0d_parity_flag_bad", idx), pf_bad, 0);
      chk($sformatf("v%0d_idle_after", idx), {31'd0, s_busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] rec;
      int          bad, acc, stray;

      vecs[0] = '{word: 32'hA5A5_0F01, msb: 1'b1, first: 1'b1, last: 1'b1, par: 1'b1};
      vecs[1] = '{word: 32'hFFFF_0000, msb: 1'b1, first: 1'b1, last: 1'b0, par: 1'b0};
      vecs[2] = '{word: 32'h0000_0001, msb: 1'b0, first: 1'b1, last: 1'b0, par: 1'b1};
      vecs[3] = '{word: 32'h1234_5678, msb: 1'b1, first: 1'b0, last: 1'b0, par: 1'b1};
      vecs[4] = '{word: 32'h8000_0000, msb: 1'b0, first: 1'b0, last: 1'b1, par: 1'b1};
      vecs[5] = '{word: 32'h0000_0007, msb: 1'b1, first: 1'b0, last: 1'b1, par: 1'b1};

      drive(1'b1, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 32'd0);
      repeat (3) tick();
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset with no valid, both instances.
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         sel = 1'b1; #1; idle_bad(bad); acc += bad;
         sel = 1'b0; #1; idle_bad(bad); acc += bad;
      end
      chk("reset_idle_bad", acc, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Back-to-back: second word held, first bit of frame two directly after frame one.
      sel = 1'b1;
      #1;
      rec = '0;
      drive(1'b1, 1'b1, 32'hFFFF_0000);
      tick();
      rec = {rec[30:0], s_ser};
      drive(1'b1, 1'b1, 32'h1234_5678);
      tick();
      rec = {rec[30:0], s_ser};
      drive(1'b1, 1'b0, 32'd0);
      chk("b2b_ready_low", {31'd0, s_rdy}, 32'd0);
      for (int i = 2; i < FL; i++) begin
         tick();
         if (i < 32) rec = {rec[30:0], s_ser};
      end
      tick();
      chk("b2b_siso_word1", rec, 32'hFFFF_0000);
      chk("b2b_frame2_start", {31'd0, s_fs}, 32'd1);
      chk("b2b_frame2_cnt", {26'd0, s_cnt}, 32'd0);
      chk("b2b_ready_back", {31'd0, s_rdy}, 32'd1);
      capture_frame(1'b1, rec);
      chk("b2b_word2", rec, 32'h1234_5678);
      chk("b2b_idle_after", {31'd0, s_busy}, 32'd0);

      // Asynchronous reset at bit 10 with a word held.
      drive(1'b1, 1'b1, 32'hA5A5_0F01);
      tick();
      drive(1'b1, 1'b1, 32'h0F0F_F0F0);
      tick();
      drive(1'b1, 1'b0, 32'd0);
      repeat (9) tick();
      chk("rst_pre_cnt", {26'd0, s_cnt}, 32'd10);
      #2;
      rst_n = 1'b0;
      #1;
      idle_bad(bad);
      chk("rst_async_clear_bad", bad, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         idle_bad(bad);
         stray += bad;
      end
      chk("rst_no_resume_bad", stray, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end
endmodule
